// File: rtl/risc_ctrl_unit.sv
// risc_ctrl_unit: multi-cycle fetch/decode/execute control FSM for the 8-bit RISC SPM
module risc_ctrl_unit #(
    parameter int IW = 8,
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic          cu_clk,
    input  logic          cu_rst,
    input  logic [IW-1:0] cu_ir,
    input  logic          cu_zflag,
    output logic          cu_ir_wr_en,
    output logic          cu_ir_rd_en,
    output logic          cu_pc_ld,
    output logic          cu_pc_inc,
    output logic          cu_ar_ld,
    output logic          cu_mem_wr,
    output logic [2:0]    cu_bus_sel,
    output logic [3:0]    cu_reg_ld,
    output logic          cu_alu_go,
    output logic          cu_halt,
    output logic [3:0]    cu_state
);
    typedef enum logic [3:0] {
        IDLE = 4'd0, FET1 = 4'd1, FET2 = 4'd2, DEC = 4'd3, EXE = 4'd4,
        RD1 = 4'd5, RD2 = 4'd6, RD3 = 4'd7, WR1 = 4'd8, WR2 = 4'd9, WR3 = 4'd10,
        BR1 = 4'd11, BR2 = 4'd12, SKP = 4'd13, HALT = 4'd14
    } state_t;

    state_t state_q, state_d;
    logic [3:0] opc, dest_oh;
    logic [1:0] src, dest;

    assign opc     = cu_ir[IW-1 -: 4];
    assign src     = cu_ir[3:2];
    assign dest    = cu_ir[1:0];
    assign dest_oh = 4'b0001 << dest;

    always_ff @(posedge cu_clk) begin
        state_q <= cu_rst ? IDLE : state_d;
    end

    always_comb begin
        state_d     = state_q;
        cu_ir_wr_en = 1'b0;
        cu_ir_rd_en = 1'b0;
        cu_pc_ld    = 1'b0;
        cu_pc_inc   = 1'b0;
        cu_ar_ld    = 1'b0;
        cu_mem_wr   = 1'b0;
        cu_bus_sel  = 3'd0;
        cu_reg_ld   = 4'b0000;
        cu_alu_go   = 1'b0;
        cu_halt     = 1'b0;
        cu_state    = state_q;
        case (state_q)
            IDLE: state_d = FET1;
            FET1: begin
                cu_bus_sel = 3'd4;
                cu_ar_ld   = 1'b1;
                state_d    = FET2;
            end
            FET2: begin
                cu_bus_sel  = 3'd5;
                cu_ir_wr_en = 1'b1;
                cu_pc_inc   = 1'b1;
                state_d     = DEC;
            end
            DEC: begin
                cu_ir_rd_en = 1'b1;
                state_d = (opc == 4'd0) ? FET1 :
                          (opc <= 4'd4) ? EXE  :
                          (opc == 4'd5) ? RD1  :
                          (opc == 4'd6) ? WR1  :
                          (opc == 4'd7) ? BR1  :
                          (opc == 4'd8) ? (cu_zflag ? BR1 : SKP) :
                          (HALT_ON_ILLEGAL ? HALT : FET1);
            end
            EXE: begin
                cu_ir_rd_en = 1'b1;
                cu_bus_sel  = {1'b0, src};
                cu_alu_go   = 1'b1;
                cu_reg_ld   = dest_oh;
                state_d     = FET1;
            end
            RD1, WR1: begin
                cu_ir_rd_en = 1'b1;
                cu_bus_sel  = 3'd4;
                cu_ar_ld    = 1'b1;
                cu_pc_inc   = 1'b1;
                state_d     = (state_q == RD1) ? RD2 : WR2;
            end
            RD2, WR2: begin
                cu_ir_rd_en = 1'b1;
                cu_bus_sel  = 3'd5;
                cu_ar_ld    = 1'b1;
                state_d     = (state_q == RD2) ? RD3 : WR3;
            end
            RD3: begin
                cu_ir_rd_en = 1'b1;
                cu_bus_sel  = 3'd5;
                cu_reg_ld   = dest_oh;
                state_d     = FET1;
            end
            WR3: begin
                cu_ir_rd_en = 1'b1;
                cu_bus_sel  = {1'b0, src};
                cu_mem_wr   = 1'b1;
                state_d     = FET1;
            end
            BR1: begin
                cu_ir_rd_en = 1'b1;
                cu_bus_sel  = 3'd4;
                cu_ar_ld    = 1'b1;
                state_d     = BR2;
            end
            BR2: begin
                cu_ir_rd_en = 1'b1;
                cu_bus_sel  = 3'd5;
                cu_pc_ld    = 1'b1;
                state_d     = FET1;
            end
            SKP: begin
                cu_ir_rd_en = 1'b1;
                cu_pc_inc   = 1'b1;
                state_d     = FET1;
            end
            HALT: cu_halt = 1'b1;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_risc_ctrl_unit.sv
// tb_risc_ctrl_unit: directed checks of the control FSM state walk and strobes
module tb_risc_ctrl_unit;
    logic       cu_clk = 1'b0, cu_rst = 1'b1, cu_zflag = 1'b0;
    logic [7:0] cu_ir = 8'h00;
    logic       ir_wr_en, ir_rd_en, pc_ld, pc_inc, ar_ld, mem_wr, alu_go, halt;
    logic [2:0] bus_sel;
    logic [3:0] reg_ld, state;
    logic       n_ir_wr_en, n_ir_rd_en, n_pc_ld, n_pc_inc, n_ar_ld, n_mem_wr, n_alu_go, n_halt;
    logic [2:0] n_bus_sel;
    logic [3:0] n_reg_ld, n_state;
    logic [18:0] obs, n_obs;
    int checks = 0, errors = 0;

    // {ir_wr_en, ir_rd_en, pc_ld, pc_inc, ar_ld, mem_wr, bus_sel, reg_ld, alu_go, halt, state}
    localparam logic [18:0] S_IDLE = {6'b000000, 3'd0, 4'b0000, 2'b00, 4'd0};
    localparam logic [18:0] S_FET1 = {6'b000010, 3'd4, 4'b0000, 2'b00, 4'd1};
    localparam logic [18:0] S_FET2 = {6'b100100, 3'd5, 4'b0000, 2'b00, 4'd2};
    localparam logic [18:0] S_DEC  = {6'b010000, 3'd0, 4'b0000, 2'b00, 4'd3};
    localparam logic [18:0] S_EXE  = {6'b010000, 3'd1, 4'b0100, 2'b10, 4'd4};
    localparam logic [18:0] S_RD1  = {6'b010110, 3'd4, 4'b0000, 2'b00, 4'd5};
    localparam logic [18:0] S_RD2  = {6'b010010, 3'd5, 4'b0000, 2'b00, 4'd6};
    localparam logic [18:0] S_RD3  = {6'b010000, 3'd5, 4'b1000, 2'b00, 4'd7};
    localparam logic [18:0] S_WR1  = {6'b010110, 3'd4, 4'b0000, 2'b00, 4'd8};
    localparam logic [18:0] S_WR2  = {6'b010010, 3'd5, 4'b0000, 2'b00, 4'd9};
    localparam logic [18:0] S_WR3  = {6'b010001, 3'd2, 4'b0000, 2'b00, 4'd10};
    localparam logic [18:0] S_BR1  = {6'b010010, 3'd4, 4'b0000, 2'b00, 4'd11};
    localparam logic [18:0] S_BR2  = {6'b011000, 3'd5, 4'b0000, 2'b00, 4'd12};
    localparam logic [18:0] S_SKP  = {6'b010100, 3'd0, 4'b0000, 2'b00, 4'd13};
    localparam logic [18:0] S_HALT = {6'b000000, 3'd0, 4'b0000, 2'b01, 4'd14};

    risc_ctrl_unit dut (
        .cu_clk(cu_clk), .cu_rst(cu_rst), .cu_ir(cu_ir), .cu_zflag(cu_zflag),
        .cu_ir_wr_en(ir_wr_en), .cu_ir_rd_en(ir_rd_en), .cu_pc_ld(pc_ld), .cu_pc_inc(pc_inc),
        .cu_ar_ld(ar_ld), .cu_mem_wr(mem_wr), .cu_bus_sel(bus_sel), .cu_reg_ld(reg_ld),
        .cu_alu_go(alu_go), .cu_halt(halt), .cu_state(state)
    );

    risc_ctrl_unit #(.HALT_ON_ILLEGAL(1'b0)) dut_nh (
        .cu_clk(cu_clk), .cu_rst(cu_rst), .cu_ir(cu_ir), .cu_zflag(cu_zflag),
        .cu_ir_wr_en(n_ir_wr_en), .cu_ir_rd_en(n_ir_rd_en), .cu_pc_ld(n_pc_ld), .cu_pc_inc(n_pc_inc),
        .cu_ar_ld(n_ar_ld), .cu_mem_wr(n_mem_wr), .cu_bus_sel(n_bus_sel), .cu_reg_ld(n_reg_ld),
        .cu_alu_go(n_alu_go), .cu_halt(n_halt), .cu_state(n_state)
    );

    assign obs   = {ir_wr_en, ir_rd_en, pc_ld, pc_inc, ar_ld, mem_wr, bus_sel, reg_ld, alu_go, halt, state};
    assign n_obs = {n_ir_wr_en, n_ir_rd_en, n_pc_ld, n_pc_inc, n_ar_ld, n_mem_wr, n_bus_sel, n_reg_ld,
                    n_alu_go, n_halt, n_state};

    always #5 cu_clk = ~cu_clk;

    task automatic step();
        @(posedge cu_clk);
        #1;
    endtask

    task automatic test_reset();
        logic [18:0] e[$];
        cu_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (obs !== S_IDLE) begin errors++; $display("FAIL reset_hold[%0d] got %h exp %h", i, obs, S_IDLE); end
        end
        cu_rst = 1'b0;
        cu_ir = 8'h00;
        e = '{S_FET1, S_FET2, S_DEC, S_FET1};
        foreach (e[i]) begin
            step();
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL reset_release_nop[%0d] got %h exp %h", i, obs, e[i]); end
        end
    endtask

    task automatic test_alu();
        logic [18:0] e[$];
        cu_ir = 8'h16;
        e = '{S_FET2, S_DEC, S_EXE, S_FET1};
        foreach (e[i]) begin
            step();
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL alu_add[%0d] got %h exp %h", i, obs, e[i]); end
        end
    endtask

    task automatic test_mem();
        logic [18:0] e[$];
        cu_ir = 8'h53;
        e = '{S_FET2, S_DEC, S_RD1, S_RD2, S_RD3, S_FET1};
        foreach (e[i]) begin
            step();
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL mem_rd[%0d] got %h exp %h", i, obs, e[i]); end
        end
        cu_ir = 8'h68;
        e = '{S_FET2, S_DEC, S_WR1, S_WR2, S_WR3, S_FET1};
        foreach (e[i]) begin
            step();
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL mem_wr[%0d] got %h exp %h", i, obs, e[i]); end
        end
    endtask

    task automatic test_branch();
        logic [18:0] e[$];
        cu_ir = 8'h80;
        cu_zflag = 1'b1;
        e = '{S_FET2, S_DEC, S_BR1, S_BR2, S_FET1};
        foreach (e[i]) begin
            step();
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL brz_taken[%0d] got %h exp %h", i, obs, e[i]); end
        end
        cu_zflag = 1'b0;
        e = '{S_FET2, S_DEC, S_SKP, S_FET1};
        foreach (e[i]) begin
            step();
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL brz_skip[%0d] got %h exp %h", i, obs, e[i]); end
        end
        cu_ir = 8'h70;
        e = '{S_FET2, S_DEC, S_BR1, S_BR2, S_FET1};
        foreach (e[i]) begin
            step();
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL br_z0[%0d] got %h exp %h", i, obs, e[i]); end
        end
        cu_zflag = 1'b1;
        foreach (e[i]) begin
            step();
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL br_z1[%0d] got %h exp %h", i, obs, e[i]); end
        end
        cu_zflag = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [18:0] e[$];
        cu_ir = 8'h68;
        e = '{S_FET2, S_DEC, S_WR1, S_WR2, S_WR3};
        foreach (e[i]) begin
            step();
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL mid_wr[%0d] got %h exp %h", i, obs, e[i]); end
        end
        cu_rst = 1'b1;
        step();
        checks++;
        if (obs !== S_IDLE) begin errors++; $display("FAIL mid_reset got %h exp %h", obs, S_IDLE); end
        cu_rst = 1'b0;
        step();
        checks++;
        if (obs !== S_FET1) begin errors++; $display("FAIL mid_restart got %h exp %h", obs, S_FET1); end
    endtask

    task automatic test_illegal();
        logic [18:0] e[$];
        cu_ir = 8'hF0;
        e = '{S_FET2, S_DEC, S_HALT};
        foreach (e[i]) begin
            step();
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL illegal_entry[%0d] got %h exp %h", i, obs, e[i]); end
        end
        cu_zflag = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cu_ir = (i % 2 == 0) ? 8'h16 : 8'h80;
            step();
            checks++;
            if (obs !== S_HALT) begin errors++; $display("FAIL halt_hold[%0d] got %h exp %h", i, obs, S_HALT); end
        end
        cu_zflag = 1'b0;
        cu_rst = 1'b1;
        step();
        checks++;
        if (obs !== S_IDLE) begin errors++; $display("FAIL halt_reset got %h exp %h", obs, S_IDLE); end
        cu_rst = 1'b0;
        step();
        checks++;
        if (obs !== S_FET1) begin errors++; $display("FAIL halt_restart got %h exp %h", obs, S_FET1); end
    endtask

    task automatic test_no_halt();
        logic [18:0] e[$];
        logic [18:0] en[$];
        checks++;
        if (n_obs !== S_FET1) begin errors++; $display("FAIL nohalt_start got %h exp %h", n_obs, S_FET1); end
        cu_ir = 8'h90;
        e  = '{S_FET2, S_DEC, S_HALT};
        en = '{S_FET2, S_DEC, S_FET1};
        foreach (e[i]) begin
            step();
            checks++;
            if (obs !== e[i]) begin errors++; $display("FAIL op9_halt[%0d] got %h exp %h", i, obs, e[i]); end
            checks++;
            if (n_obs !== en[i]) begin errors++; $display("FAIL op9_nohalt[%0d] got %h exp %h", i, n_obs, en[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mem();
        test_branch();
        test_reset_mid();
        test_illegal();
        test_no_halt();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/risc_ctrl_unit.md
Name: risc_ctrl_unit

Overview:
- Multi-cycle control FSM for the 8-bit RISC SPM. It is the consumer of the instruction register interface.
- It sequences fetch, writing memory data into the IR via ir_wr_en.
- It then decodes the IR contents it reads back (holding ir_rd_en high while an instruction executes).
- It drives all datapath load, select and memory-write strobes.
- Instruction format: opcode [7:4], src reg [3:2], dest reg [1:0].

Parameters:
- IW, 8, instruction width (bits; opcode in top 4 bits).
- HALT_ON_ILLEGAL, 1, 1: opcodes 9-15 enter HALT. 0: they are treated as NOP.

Ports:
- cu_clk  in  1  clock; all state changes on the rising edge.
- cu_rst  in  1  synchronous, active-high reset.
- cu_ir  in  IW  instruction register output (opcode/src/dest).
- cu_zflag  in  1  registered ALU zero flag from the datapath.
- cu_ir_wr_en  out  1  load the IR from the memory bus.
- cu_ir_rd_en  out  1  IR full-word read enable; high from DEC through the end of execute.
- cu_pc_ld  out  1  load the PC from the bus.
- cu_pc_inc  out  1  increment the PC.
- cu_ar_ld  out  1  load the address register from the bus.
- cu_mem_wr  out  1  memory write strobe (write address = AR, data = bus).
- cu_bus_sel  out  3  bus source: 0-3 = R0-R3, 4 = PC, 5 = MEM, 6/7 unused.
- cu_reg_ld  out  4  one-hot register load, R0-R3.
- cu_alu_go  out  1  ALU result is routed to the register input; the zero flag updates.
- cu_halt  out  1  high while in HALT.
- cu_state  out  4  current state encoding, for debug.

Behaviour:
- Reset:
  - cu_rst sampled high at an edge forces state IDLE after that edge, from any state.
  - An operation in progress is abandoned; no strobe survives the edge.
  - In IDLE all outputs are 0, except cu_state = 0.
- Outputs are Moore: a pure function of state and cu_ir. No output depends on cu_zflag combinationally.
- State encodings: IDLE 0, FET1 1, FET2 2, DEC 3, EXE 4, RD1 5, RD2 6, RD3 7, WR1 8, WR2 9, WR3 10, BR1 11, BR2 12, SKP 13, HALT 14.
- IDLE -> FET1 unconditionally on the first edge with cu_rst low.
- FET1: bus_sel=4, ar_ld=1. Next state FET2.
- FET2: bus_sel=5, ir_wr_en=1, pc_inc=1. Next state DEC.
- DEC: ir_rd_en=1, no other strobes. Next state by opcode:
  - 0 NOP -> FET1.
  - 1 ADD, 2 SUB, 3 AND, 4 NOT -> EXE.
  - 5 RD -> RD1.
  - 6 WR -> WR1.
  - 7 BR -> BR1.
  - 8 BRZ -> BR1 if cu_zflag=1, else SKP.
  - 9-15 -> HALT (or FET1 if HALT_ON_ILLEGAL=0).
- EXE: ir_rd_en=1, bus_sel={0,src}, alu_go=1, reg_ld=onehot(dest). Next state FET1.
- Two-word instructions: the second word (operand address) is fetched at PC.
  - RD1 and WR1: bus_sel=4, ar_ld=1, pc_inc=1.
  - RD2 and WR2: bus_sel=5, ar_ld=1.
  - RD3: bus_sel=5, reg_ld=onehot(dest). Next state FET1.
  - WR3: bus_sel={0,src}, mem_wr=1. Next state FET1.
  - ir_rd_en=1 throughout these states.
- BR1: bus_sel=4, ar_ld=1. BR2: bus_sel=5, pc_ld=1. Next state FET1.
- SKP (BRZ not taken): pc_inc=1 to skip the target word. Next state FET1.
- HALT: cu_halt=1, all strobes 0. Absorbing until cu_rst.
- Invariants:
  - At most one of pc_ld/pc_inc per cycle.
  - cu_mem_wr only in WR3.
  - cu_reg_ld at most one-hot, and non-zero only in EXE/RD3.
  - cu_ir_wr_en only in FET2.
  - cu_ir is ignored outside DEC..execute states. The IR changes only in FET2, so decode is stable.
- Cycle counts from entering FET1 to the next FET1:
  - NOP 3.
  - ALU ops 4.
  - RD/WR 6.
  - BR 5.
  - BRZ taken 5, not taken 4.

Test Plan:
- Reset and release: hold cu_rst 3 cycles then release -> cu_state sequence 0,1,2,3 on successive edges. FET1 shows bus_sel=4, ar_ld=1. FET2 shows ir_wr_en=1, pc_inc=1.
- ALU op: cu_ir=8'h16 (ADD src R1, dest R2) at DEC -> EXE cycle has bus_sel=1, reg_ld=4'b0100, alu_go=1, ir_rd_en=1. FET1 follows.
- Memory ops: cu_ir=8'h53 (RD to R3) -> states 5,6,7, with reg_ld=4'b1000 only in RD3. cu_ir=8'h68 (WR from R2) -> states 8,9,10, with mem_wr=1 and bus_sel=2 only in WR3.
- Branches:
  - cu_ir=8'h80 with cu_zflag=1 -> BR1, BR2 (pc_ld=1).
  - Same with cu_zflag=0 -> SKP (pc_inc=1), then FET1.
  - cu_ir=8'h70 -> BR1, BR2 regardless of cu_zflag.
- Illegal opcode: cu_ir=8'hF0 -> HALT (state 14, cu_halt=1) held 20 cycles with all strobes 0. Assert cu_rst -> IDLE next edge.
- Reset mid-operation: assert cu_rst during WR3 -> mem_wr=0 and state 0 after that edge. With HALT_ON_ILLEGAL=0, cu_ir=8'h90 -> FET1 directly after DEC.
